// File: rtl/bus_region_controller.sv
// Registered base/mask region decoder for the CPU bus: one-hot select held for the
// whole access, single-cycle ready from a fixed wait count or a device ack with timeout.
module bus_region_controller #(
  parameter int                            ADDR_W          = 32,
  parameter int                            NUM_REGIONS     = 4,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE     = {32'h08000000, 32'h04010000,
                                                              32'h00400000, 32'h00000000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK     = {32'hFC000000, 32'hFFFFFFF0,
                                                              32'hFFFF0000, 32'hFFFF8000},
  parameter logic [NUM_REGIONS-1:0]        REGION_ACK_MODE = 4'b1100,
  parameter logic [NUM_REGIONS*4-1:0]      REGION_WAIT     = {4'd0, 4'd0, 4'd1, 4'd0},
  parameter logic [7:0]                    TIMEOUT         = 8'd255
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req,
  input  logic [ADDR_W-1:0]      addr,
  output logic [NUM_REGIONS-1:0] sel,
  output logic [ADDR_W-1:0]      local_addr,
  input  logic [NUM_REGIONS-1:0] region_ack,
  output logic                   ready,
  output logic                   bus_err,
  output logic [ADDR_W-1:0]      err_addr,
  output logic [7:0]             err_cnt,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERR    = 2'd2
  } state_t;

  state_t                 state_q;
  logic [NUM_REGIONS-1:0] sel_q;
  logic [ADDR_W-1:0]      local_addr_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [ADDR_W-1:0]      err_addr_q;
  logic [7:0]             err_cnt_q;
  logic [7:0]             cnt_q;
  logic                   ack_mode_q;

  logic                   hit;
  logic [NUM_REGIONS-1:0] hit_sel;
  logic [ADDR_W-1:0]      hit_mask;
  logic [3:0]             hit_wait;
  logic                   hit_ack_mode;
  logic                   ack_hit;
  logic                   cnt_zero;
  logic                   ready_c;
  logic                   err_c;

  // Scan from the top index down so the lowest matching region is the last assignment.
  always_comb begin
    hit          = 1'b0;
    hit_sel      = '0;
    hit_mask     = '0;
    hit_wait     = '0;
    hit_ack_mode = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if ((addr & REGION_MASK[i*ADDR_W +: ADDR_W]) == REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        hit          = 1'b1;
        hit_sel      = '0;
        hit_sel[i]   = 1'b1;
        hit_mask     = REGION_MASK[i*ADDR_W +: ADDR_W];
        hit_wait     = REGION_WAIT[i*4 +: 4];
        hit_ack_mode = REGION_ACK_MODE[i];
      end
    end
  end

  // sel_q is one-hot during ACCESS, so masking the acks picks the selected region's ack.
  assign ack_hit  = |(region_ack & sel_q);
  assign cnt_zero = (cnt_q == 8'd0);

  always_comb begin
    ready_c = 1'b0;
    err_c   = 1'b0;
    case (state_q)
      ACCESS: begin
        if (ack_mode_q) begin
          ready_c = ack_hit | cnt_zero;
          err_c   = ~ack_hit & cnt_zero;
        end else begin
          ready_c = cnt_zero;
        end
      end
      ERR: begin
        ready_c = 1'b1;
        err_c   = 1'b1;
      end
      default: begin
        ready_c = 1'b0;
        err_c   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      local_addr_q <= '0;
      addr_q       <= '0;
      err_addr_q   <= '0;
      err_cnt_q    <= '0;
      cnt_q        <= '0;
      ack_mode_q   <= 1'b0;
    end else begin
      if (err_c) begin
        err_addr_q <= addr_q;
        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
      end
      case (state_q)
        IDLE: begin
          if (req) begin
            addr_q <= addr;
            if (hit) begin
              state_q      <= ACCESS;
              sel_q        <= hit_sel;
              local_addr_q <= addr & ~hit_mask;
              ack_mode_q   <= hit_ack_mode;
              cnt_q        <= hit_ack_mode ? TIMEOUT : {4'd0, hit_wait};
            end else begin
              state_q <= ERR;
            end
          end
        end
        ACCESS: begin
          if (ready_c) begin
            state_q <= IDLE;
            sel_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 8'd1;
          end
        end
        ERR:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sel        = sel_q;
  assign local_addr = local_addr_q;
  assign ready      = ready_c;
  assign bus_err    = err_c;
  assign err_addr   = err_addr_q;
  assign err_cnt    = err_cnt_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_bus_region_controller.sv
// Bench for bus_region_controller: directed access table with hand-derived latencies,
// then per-cycle comparison against a transaction-level reference model.
module tb_bus_region_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  region_ack = '0;
  logic [3:0]  sel;
  logic [31:0] local_addr;
  logic        ready;
  logic        bus_err;
  logic [31:0] err_addr;
  logic [7:0]  err_cnt;
  logic [1:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  bus_region_controller dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .sel(sel),
    .local_addr(local_addr), .region_ack(region_ack), .ready(ready),
    .bus_err(bus_err), .err_addr(err_addr), .err_cnt(err_cnt), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

  // Region map of the default configuration, written as plain tables.
  logic [31:0] r_base[4] = '{32'h00000000, 32'h00400000, 32'h04010000, 32'h08000000};
  logic [31:0] r_mask[4] = '{32'hFFFF8000, 32'hFFFF0000, 32'hFFFFFFF0, 32'hFC000000};
  int          r_wait[4] = '{0, 1, 0, 0};
  bit          r_ackm[4] = '{0, 0, 1, 1};
  localparam int TIMEOUT_CYC = 255;

  function automatic int decode(input logic [31:0] a);
    for (int i = 0; i < 4; i++)
      if ((a & r_mask[i]) == r_base[i]) return i;
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: one transaction at a time ----------------
  bit          m_busy;
  bit          m_unmapped;
  int          m_region;
  int          m_age;
  logic [31:0] m_addr, m_local, m_err_addr;
  int          m_err_cnt;

  task automatic model_clear();
    m_busy = 0; m_unmapped = 0; m_region = 0; m_age = 0;
    m_addr = '0; m_local = '0; m_err_addr = '0; m_err_cnt = 0;
  endtask

  // Compare one cycle at the falling edge, then advance the model across the rising edge.
  task automatic step();
    logic [3:0] one;
    logic [3:0] e_sel;
    logic       e_ready, e_err, ack;
    int         r;
    one = 4'b0001;
    @(negedge clk);
    e_sel = '0; e_ready = 0; e_err = 0;
    if (m_busy && m_unmapped) begin
      e_ready = 1; e_err = 1;
    end else if (m_busy) begin
      e_sel = one << m_region;
      if (r_ackm[m_region]) begin
        ack     = region_ack[m_region];
        e_ready = ack || (m_age == TIMEOUT_CYC);
        e_err   = !ack && (m_age == TIMEOUT_CYC);
      end else begin
        e_ready = (m_age == r_wait[m_region]);
      end
    end
    n_vec++;
    if (sel !== e_sel || ready !== e_ready || bus_err !== e_err || local_addr !== m_local ||
        err_addr !== m_err_addr || err_cnt !== 8'(m_err_cnt)) begin
      n_err++;
      $display("FAIL cycle t=%0t: got sel=%b rdy=%b err=%b la=%h ea=%h ec=%0d expected sel=%b rdy=%b err=%b la=%h ea=%h ec=%0d",
               $time, sel, ready, bus_err, local_addr, err_addr, err_cnt,
               e_sel, e_ready, e_err, m_local, m_err_addr, m_err_cnt);
    end
    if (!rst_n) begin
      model_clear();
    end else begin
      if (e_err) begin
        m_err_addr = m_addr;
        if (m_err_cnt < 255) m_err_cnt++;
      end
      if (m_busy) begin
        if (e_ready) m_busy = 0;
        else m_age++;
      end else if (req) begin
        r = decode(addr);
        m_busy = 1; m_age = 0; m_addr = addr;
        m_unmapped = (r < 0);
        if (r >= 0) begin
          m_region = r;
          m_local  = addr & ~r_mask[r];
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    rst_n = 0; req = 0; region_ack = '0;
    repeat (2) @(posedge clk);
    #1;
    model_clear();
    rst_n = 1;
  endtask

  // ---------------- directed access table ----------------
  typedef struct {
    logic [31:0] addr;
    int          ack_at;
    logic [3:0]  ack_bits;
    int          stray_at;
    logic [3:0]  stray_bits;
    logic [3:0]  exp_sel;
    int          exp_lat;
    logic        exp_err;
    logic [31:0] exp_local;
  } vec_t;

  vec_t vecs[$];
  int   exp_errs = 0;

  task automatic run_vec(input vec_t v, input int id);
    bit          got;
    int          lat;
    logic [3:0]  c_sel;
    logic        c_err;
    logic [31:0] c_local;
    string       tag;
    got = 0; lat = 0; c_sel = '0; c_err = 0; c_local = '0;
    tag = $sformatf("vec%0d", id);
    req = 1; addr = v.addr; region_ack = '0;
    @(posedge clk);
    #1;
    for (int n = 1; n <= 300 && !got; n++) begin
      region_ack = ((n == v.ack_at) ? v.ack_bits : 4'b0) | ((n == v.stray_at) ? v.stray_bits : 4'b0);
      if (n == 2) addr = ~v.addr;
      @(negedge clk);
      if (ready) begin
        got = 1; lat = n; c_sel = sel; c_err = bus_err; c_local = local_addr;
      end
      @(posedge clk);
      #1;
    end
    req = 0; region_ack = '0;
    check({tag, " latency"}, 64'(lat), 64'(v.exp_lat));
    check({tag, " sel"}, 64'(c_sel), 64'(v.exp_sel));
    check({tag, " bus_err"}, 64'(c_err), 64'(v.exp_err));
    if (v.exp_sel != 4'b0) check({tag, " local_addr"}, 64'(c_local), 64'(v.exp_local));
    @(negedge clk);
    check({tag, " idle after"}, {59'd0, sel, ready}, 64'd0);
    if (v.exp_err) begin
      exp_errs++;
      check({tag, " err_addr"}, 64'(err_addr), 64'(v.addr));
    end
    check({tag, " err_cnt"}, 64'(err_cnt), 64'(exp_errs));
    @(posedge clk);
    #1;
  endtask

  initial begin
    //           addr          ack  bits     stray bits     sel      lat  err  local
    vecs.push_back('{32'h00000010,   0, 4'b0000, 0, 4'b0000, 4'b0001,   1, 0, 32'h00000010});
    vecs.push_back('{32'h00007FFC,   0, 4'b0000, 0, 4'b0000, 4'b0001,   1, 0, 32'h00007FFC});
    vecs.push_back('{32'h00400004,   0, 4'b0000, 1, 4'b0010, 4'b0010,   2, 0, 32'h00000004});
    vecs.push_back('{32'h0040FFFF,   0, 4'b0000, 1, 4'b1111, 4'b0010,   2, 0, 32'h0000FFFF});
    vecs.push_back('{32'h08000100,   4, 4'b1000, 2, 4'b0100, 4'b1000,   4, 0, 32'h00000100});
    vecs.push_back('{32'h0BFFFFFF,   1, 4'b1000, 0, 4'b0000, 4'b1000,   1, 0, 32'h03FFFFFF});
    vecs.push_back('{32'h0401000F,   3, 4'b0100, 0, 4'b0000, 4'b0100,   3, 0, 32'h0000000F});
    vecs.push_back('{32'h04010008,   0, 4'b0000, 5, 4'b1011, 4'b0100, 256, 1, 32'h00000008});
    vecs.push_back('{32'h04010004, 256, 4'b0100, 0, 4'b0000, 4'b0100, 256, 0, 32'h00000004});
    vecs.push_back('{32'h00010000,   0, 4'b0000, 0, 4'b0000, 4'b0000,   1, 1, 32'h00000000});
    vecs.push_back('{32'h04010010,   0, 4'b0000, 0, 4'b0000, 4'b0000,   1, 1, 32'h00000000});
    vecs.push_back('{32'h00008000,   0, 4'b0000, 0, 4'b0000, 4'b0000,   1, 1, 32'h00000000});
    vecs.push_back('{32'h08000000,   2, 4'b1111, 0, 4'b0000, 4'b1000,   2, 0, 32'h00000000});

    // Reset state
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset sel", 64'(sel), 64'd0);
    check("reset ready/bus_err", {62'd0, ready, bus_err}, 64'd0);
    check("reset local_addr", 64'(local_addr), 64'd0);
    check("reset err_addr", 64'(err_addr), 64'd0);
    check("reset err_cnt", 64'(err_cnt), 64'd0);
    check("reset state", 64'(state_dbg), 64'd0);
    rst_n = 1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) run_vec(vecs[i], i);

    // 300 back-to-back unmapped accesses saturate the error counter.
    reset_all();
    req = 1; addr = 32'h00010000;
    repeat (600) step();
    req = 0;
    step();
    check("err_cnt saturated", 64'(err_cnt), 64'd255);

    // Reset in the middle of a region-3 access: no ready, everything cleared.
    req = 1; addr = 32'h08000100;
    step();
    step();
    rst_n = 0; req = 0;
    step();
    rst_n = 1;
    check("mid reset sel", 64'(sel), 64'd0);
    check("mid reset ready/bus_err", {62'd0, ready, bus_err}, 64'd0);
    check("mid reset local_addr", 64'(local_addr), 64'd0);
    check("mid reset err_addr", 64'(err_addr), 64'd0);
    check("mid reset err_cnt", 64'(err_cnt), 64'd0);
    req = 1; addr = 32'h00000010;
    step();
    req = 0;
    step();
    check("post reset local_addr", 64'(local_addr), 64'h10);

    // Randomized traffic against the model.
    begin
      int ack_pct;
      int r;
      ack_pct = 25;
      for (int c = 0; c < 5000; c++) begin
        if (c % 700 == 0) ack_pct = (ack_pct == 0) ? 25 : 0;
        rst_n = ($urandom_range(0, 399) != 0);
        req   = ($urandom_range(0, 3) != 0);
        r     = $urandom_range(0, 5);
        if (r < 4)       addr = r_base[r] | ($urandom() & ~r_mask[r]);
        else if (r == 4) addr = $urandom();
        else             addr = 32'h00010000;
        for (int b = 0; b < 4; b++) region_ack[b] = ($urandom_range(0, 99) < ack_pct);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_region_controller.md
# bus_region_controller

Parametrised, registered successor to the system address decoder. It maps the CPU bus address onto `NUM_REGIONS` base/mask regions and holds a registered one-hot region select for the whole access. It terminates every access with a single-cycle `ready`, using either a fixed wait-state count or a device acknowledge guarded by a timeout. Unmapped and timed-out accesses raise `bus_err`; the address and a saturating count are logged. It sits between the CPU bus master and the ROM/RAM/IO/Graphics slaves.

## Interface
- `ADDR_W`, 32: address width.
- `NUM_REGIONS`, 4: number of decoded regions, 1..16.
- `REGION_BASE`, {32'h08000000, 32'h04010000, 32'h00400000, 32'h00000000}: packed `NUM_REGIONS*ADDR_W`; region i at bits [i*ADDR_W +: ADDR_W].
- `REGION_MASK`, {32'hFC000000, 32'hFFFFFFF0, 32'hFFFF0000, 32'hFFFF8000}: packed like `REGION_BASE`; a 1 bit means the address bit is compared.
- `REGION_ACK_MODE`, 4'b1100: bit i = 1 means region i ends on `region_ack[i]`; 0 means fixed wait.
- `REGION_WAIT`, {4'd0, 4'd0, 4'd1, 4'd0}: packed 4 bits per region; wait states for fixed-mode regions.
- `TIMEOUT`, 8'd255: ack-mode limit in cycles, minus 1.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req`  in  1  access request from master, held until `ready`.
- `addr`  in  ADDR_W  access address.
- `sel`  out  NUM_REGIONS  registered one-hot region select.
- `local_addr`  out  ADDR_W  latched `addr & ~mask` of the selected region.
- `region_ack`  in  NUM_REGIONS  per-region device acknowledge.
- `ready`  out  1  access complete, one-cycle pulse.
- `bus_err`  out  1  qualifies `ready`: access failed.
- `err_addr`  out  ADDR_W  address of the most recent failed access.
- `err_cnt`  out  8  saturating count of failed accesses.

## Operation
- Hit rule: region i hits when `(addr & MASK[i]) == BASE[i]`. If several regions hit, the lowest index wins. The design requires `BASE[i] & ~MASK[i] == 0` for every region.
- FSM states are IDLE, ACCESS and ERR.
- IDLE:
  - `sel`, `ready` and `bus_err` are 0.
  - On `req=1`, latch the address and winning index. Go to ACCESS with `sel` set to the one-hot of the winner, `local_addr` set to `addr & ~MASK[i]`, and the counter loaded with `REGION_WAIT[i]` (fixed mode) or `TIMEOUT` (ack mode).
  - With no hit, go to ERR.
- ACCESS:
  - Fixed mode: `ready=1` while the counter is 0, then go to IDLE. Otherwise decrement the counter.
  - Ack mode: `ready=1` in any cycle where `region_ack[idx]=1`, then go to IDLE.
  - Ack mode timeout: if the counter is 0 and there is no ack, `ready=1` and `bus_err=1`, then go to IDLE. Otherwise decrement the counter.
  - `region_ack` bits for non-selected regions, and for fixed-mode regions, are ignored.
- ERR: `ready=1`, `bus_err=1`, `sel=0` for one cycle, then go to IDLE.
- Error logging:
  - On every `bus_err` cycle, `err_addr` is loaded with the latched address.
  - `err_cnt` increments on each `bus_err` cycle and saturates at 255.
- `addr` changes after acceptance are ignored; the latched value is used.
- `req` dropping mid-access does not abort the access; it completes normally.
- Reset: `rst_n=0` at any edge, including mid-access, returns the FSM to IDLE. All outputs go to 0, including `sel`, `local_addr`, `ready`, `bus_err`, `err_addr` and `err_cnt`. No `ready` is issued for the aborted access.

## Timing
- `req` sampled in IDLE at edge k: `sel` is valid from cycle k+1.
- Fixed wait W: `ready` is high in cycle k+1+W and `sel` is high in cycles k+1..k+1+W. W=0 gives `ready` in the same cycle `sel` first rises.
- Ack mode: `ready` is combinational from `region_ack[idx]` during ACCESS. Earliest completion is cycle k+1.
- Timeout: with no ack, `bus_err` is high in cycle k+1+TIMEOUT.
- Ack arriving in the same cycle the counter reaches 0 completes the access successfully (no error).
- Unmapped address: `ready=bus_err=1` in cycle k+1.
- Each access returns to IDLE for at least one cycle. A `req` still held after `ready` starts a new access, sampled on the next IDLE cycle.
- Throughput is at most one access per W+2 cycles.

## Test plan
- Default parameters, `addr=0x00000010`, `req` held:
  - `sel=0001` in cycle k+1 with `ready` high in the same cycle.
  - `local_addr=0x10`, `bus_err=0`.
- `addr=0x00400004` (region 1, W=1):
  - `sel=0010` in cycles k+1 and k+2, `ready` in k+2.
  - `sel=0` in k+3.
- `addr=0x08000100` (ack mode), `region_ack[3]` pulsed in cycle k+4:
  - `ready=1`, `bus_err=0` in k+4.
  - A stray `region_ack[2]` earlier in the access is ignored.
- `addr=0x04010008` (ack mode) with no ack:
  - `ready=bus_err=1` in cycle k+256.
  - `err_addr=0x04010008`, `err_cnt=1`.
- `addr=0x00010000` (unmapped), repeated 300 times:
  - Each access gives `ready=bus_err=1` in cycle k+1 with `sel=0`.
  - `err_cnt` ends at 255.
- Start the region-3 access, then `rst_n=0` in cycle k+2:
  - All outputs are 0 in the next cycle.
  - No `ready` is issued.
  - A new `req` after reset decodes normally.
